// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 active-low keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD} keypad_state_t;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;

  function automatic logic [3:0] kp_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Lowest-numbered row that is pulled low wins.
  function automatic logic [1:0] kp_low_row(input logic [KP_ROWS-1:0] rows);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < KP_ROWS; i++) begin
      if (!rows[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [KP_COLS-1:0] kp_col_drive(input logic [1:0] col);
    return ~(KP_COLS'(1) << col);
  endfunction

endpackage

// File: rtl/keypad_scan_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones (idle rows).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column strobe at a fixed refresh rate, debounced press/release,
// one key_valid pulse per accepted press.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_OVERFLOW  = 16'hFFFF,
  parameter int unsigned DEBOUNCE_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_select,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned     CW        = (SCAN_OVERFLOW > 0) ? $clog2(SCAN_OVERFLOW + 1) : 1;
  localparam logic [CW-1:0]   REF_MAX   = CW'(SCAN_OVERFLOW);
  localparam logic [8:0]      DB_TARGET = 9'(DEBOUNCE_TICKS);

  logic [KP_ROWS-1:0] row_s;
  logic [CW-1:0]      ref_q;
  logic               tick;

  keypad_state_t      state_q;
  logic [1:0]         col_idx_q;
  logic [3:0]         col_sel_q;
  logic [1:0]         row_idx_q;
  logic [7:0]         db_cnt_q;
  logic [3:0]         key_code_q;
  logic               key_valid_q;
  logic               key_down_q;

  logic [1:0]         col_next_d;
  logic [8:0]         db_inc_d;
  logic               db_done;
  logic               any_low;
  logic               latched_low;
  logic [1:0]         low_row;

  sync_2ff #(.WIDTH(KP_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (row_in),
    .q_o   (row_s)
  );

  always_ff @(posedge clk) begin
    if (reset || tick) ref_q <= '0;
    else               ref_q <= ref_q + CW'(1);
  end

  assign tick = (ref_q == REF_MAX);

  always_comb begin
    col_next_d  = col_idx_q + 2'd1;
    db_inc_d    = {1'b0, db_cnt_q} + 9'd1;
    db_done     = (db_inc_d >= DB_TARGET);
    any_low     = ~&row_s;
    latched_low = ~row_s[row_idx_q];
    low_row     = kp_low_row(row_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      col_sel_q   <= 4'b1110;
      row_idx_q   <= '0;
      db_cnt_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          SCAN: begin
            if (any_low) begin
              row_idx_q <= low_row;
              db_cnt_q  <= '0;
              state_q   <= PRESS_DB;
            end else begin
              col_idx_q <= col_next_d;
              col_sel_q <= kp_col_drive(col_next_d);
            end
          end
          PRESS_DB: begin
            if (!any_low) begin
              state_q <= SCAN;
            end else if (latched_low) begin
              if (db_done) begin
                key_code_q  <= kp_code(row_idx_q, col_idx_q);
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
                db_cnt_q    <= '0;
                state_q     <= HELD;
              end else begin
                db_cnt_q <= db_inc_d[7:0];
              end
            end else begin
              row_idx_q <= low_row;
              db_cnt_q  <= '0;
            end
          end
          HELD: begin
            // Release needs an unbroken run of all-high ticks; any low row restarts it.
            if (!any_low) begin
              if (db_done) begin
                key_down_q <= 1'b0;
                db_cnt_q   <= '0;
                state_q    <= SCAN;
                col_idx_q  <= col_next_d;
                col_sel_q  <= kp_col_drive(col_next_d);
              end else begin
                db_cnt_q <= db_inc_d[7:0];
              end
            end else begin
              db_cnt_q <= '0;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign col_select = col_sel_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_down   = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench: a physical keypad model drives row_in from col_select and a
// per-tick behavioural model of press/release debouncing predicts every output.
module tb_keypad_scan;

  localparam int unsigned OVF = 3;
  localparam int unsigned DB  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_select;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] mask = '0;

  int checks = 0;
  int failures = 0;

  string phase;
  int    m_col, m_row, m_cnt, m_code;
  bit    m_down, m_valid;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_OVERFLOW(OVF), .DEBOUNCE_TICKS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .row_in     (row_in),
    .col_select (col_select),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_down   (key_down)
  );

  // Key (r,c) is bit r*4+c of mask; a pressed key shorts its row to a driven-low column.
  always_comb begin
    row_in = '1;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (mask[r*4+c] && !col_select[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_cols(input int col);
    logic [3:0] one;
    one = 4'b0001;
    return 4'b1111 ^ (one << col);
  endfunction

  function automatic logic [3:0] model_rows();
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (mask[r*4+m_col]) rows[r] = 1'b0;
    return rows;
  endfunction

  task automatic model_reset();
    phase = "scan"; m_col = 0; m_row = 0; m_cnt = 0; m_code = 0;
    m_down = 0; m_valid = 0;
  endtask

  task automatic model_tick(input logic [3:0] rows);
    int low;
    low = -1;
    for (int r = 3; r >= 0; r--) if (!rows[r]) low = r;
    if (phase == "scan") begin
      if (low >= 0) begin m_row = low; m_cnt = 0; phase = "debounce"; end
      else m_col = (m_col + 1) % 4;
    end else if (phase == "debounce") begin
      if (low < 0) phase = "scan";
      else if (!rows[m_row]) begin
        m_cnt++;
        if (m_cnt == DB) begin
          m_code = m_row * 4 + m_col; m_valid = 1; m_down = 1; m_cnt = 0; phase = "held";
        end
      end else begin m_row = low; m_cnt = 0; end
    end else begin
      if (low < 0) begin
        m_cnt++;
        if (m_cnt == DB) begin m_down = 0; m_cnt = 0; phase = "scan"; m_col = (m_col + 1) % 4; end
      end else m_cnt = 0;
    end
  endtask

  task automatic check_all();
    chk("col_select", col_select, exp_cols(m_col));
    chk("key_valid", key_valid, m_valid);
    chk("key_down", key_down, m_down);
    chk("key_code", key_code, m_code);
  endtask

  task automatic do_reset(input logic [15:0] m);
    mask  = m;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  // One refresh period: three quiet clocks, then the tick edge.
  task automatic step(input logic [15:0] m);
    mask    = m;
    m_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) model_tick(model_rows());
      check_all();
    end
  endtask

  initial begin
    logic [3:0]  idle_cols [5];
    logic [15:0] rmask;
    int          hold;

    idle_cols = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset('0);
    chk("reset_col", col_select, 4'b1110);

    // Idle scan rotates through all columns.
    for (int i = 0; i < 5; i++) begin
      step('0);
      chk("idle_col", col_select, idle_cols[i]);
    end

    // Clean press of row 2 / column 1.
    for (int n = 0; n < 12 && !m_down; n++) step(16'h0200);
    chk("press_code", key_code, 4'h9);
    chk("press_down", key_down, 1'b1);
    repeat (3) step(16'h0200);
    chk("held_col", col_select, 4'b1101);

    // Release with a one-tick glitch, then a real release.
    step('0);
    chk("glitch_down", key_down, 1'b1);
    repeat (2) step(16'h0200);
    step('0);
    step('0);
    chk("release_down", key_down, 1'b0);
    chk("release_col", col_select, 4'b1011);

    // Bounce: one tick low on column 1, then high.
    for (int n = 0; n < 8 && m_col != 1; n++) step('0);
    chk("bounce_start_col", col_select, 4'b1101);
    step(16'h0200);
    step('0);
    chk("bounce_col", col_select, 4'b1101);
    chk("bounce_down", key_down, 1'b0);
    step('0);

    // Rows 0 and 3 on column 2; extra keys while held are ignored.
    for (int n = 0; n < 12 && !m_down; n++) step(16'h4004);
    chk("multi_code", key_code, 4'h2);
    repeat (4) step(16'h4054);
    chk("multi_hold_code", key_code, 4'h2);
    repeat (3) step('0);

    // Reset mid-debounce, key held throughout.
    for (int n = 0; n < 12 && phase != "debounce"; n++) step(16'h0200);
    do_reset(16'h0200);
    chk("mid_reset_col", col_select, 4'b1110);
    for (int n = 0; n < 16 && !m_down; n++) step(16'h0200);
    chk("reaccept_code", key_code, 4'h9);
    repeat (3) step('0);

    // Randomised key activity.
    rmask = '0;
    hold  = 0;
    for (int n = 0; n < 250; n++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 6);
        case ($urandom_range(0, 4))
          0, 1:    rmask = '0;
          2, 3:    rmask = 16'h0001 << $urandom_range(0, 15);
          default: rmask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        endcase
      end
      hold--;
      step(rmask);
    end
    repeat (4) step('0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
